// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default sizes for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU, EXT} owner_e;
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;
  localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU pipeline (priority) and an external port
// Ports: clk/reset (async, active-low); cpu_* pipeline access and stall; ext_* external
// request/grant/done handshake with read data; mem_* single-port synchronous memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_en,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_rw,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_done,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  owner_e state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DW-1:0] cpu_rdata_q, ext_rdata_q;
  logic ext_win;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata;
      ext_rdata_q <= ext_rdata;
    end
  end
  // Owner this cycle becomes the response state for the next; reset gates every decision.
  always_comb begin
    ext_win  = reset && ext_req && (!cpu_en || starve_q == LIMIT);
    state_d  = ext_win ? EXT : (reset && cpu_en) ? CPU : IDLE;
    starve_d = (!ext_req || ext_win) ? '0 :
               (state_d == CPU && starve_q != LIMIT) ? starve_q + SW'(1) : starve_q;
  end
  always_comb begin
    mem_en    = state_d != IDLE;
    mem_rw    = ext_win ? ext_rw : cpu_rw;
    mem_addr  = ext_win ? ext_addr : cpu_addr;
    mem_wdata = ext_win ? ext_wdata : cpu_wdata;
    ext_gnt   = ext_win;
    cpu_stall = ext_win && cpu_en;
    ext_done  = state_q == EXT;
    cpu_rdata = state_q == CPU ? mem_rdata : cpu_rdata_q;
    ext_rdata = state_q == EXT ? mem_rdata : ext_rdata_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;
  logic clk, reset;
  logic cpu_en, cpu_rw, ext_req, ext_rw;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, ext_gnt, ext_done, mem_en, mem_rw;
  logic [15:0] mem [0:255];
  logic [15:0] sb [$];
  int errors = 0;
  int checks = 0;
  dmem_arbiter #(.STARVE_LIMIT(4), .AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_rw(ext_rw), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // Synchronous one-cycle-latency memory; preloaded while reset is low.
  always @(posedge clk) begin
    if (!reset) begin
      mem[8'h10] <= 16'h1234;
      mem[8'h30] <= 16'h5555;
      mem[8'h01] <= 16'h000A;
      mem[8'h02] <= 16'h000B;
      mem[8'h03] <= 16'h000C;
      mem_rdata  <= '0;
    end else if (mem_en) begin
      if (mem_rw) mem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[7:0]];
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 0; cpu_en = 1; cpu_rw = 0; cpu_addr = 16'h0010; cpu_wdata = 0;
    ext_req = 1; ext_rw = 0; ext_addr = 16'h0030; ext_wdata = 0;
    #3;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_ext_done", ext_done, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ext_rdata", ext_rdata, 0);
    cpu_en = 0; ext_req = 0;
    tick();
    tick();
    reset = 1;
    // CPU read of 0x0010
    cpu_en = 1; cpu_rw = 0; cpu_addr = 16'h0010;
    #1;
    chk("cpu_rd_mem_en", mem_en, 1);
    chk("cpu_rd_mem_addr", mem_addr, 16'h0010);
    chk("cpu_rd_mem_rw", mem_rw, 0);
    chk("cpu_rd_stall", cpu_stall, 0);
    sb.push_back(16'h1234);
    tick();
    cpu_en = 0;
    #1;
    chk("cpu_rd_rdata", cpu_rdata, sb.pop_front());
    chk("cpu_rd_stall2", cpu_stall, 0);
    chk("idle_mem_en", mem_en, 0);
    tick();
    chk("cpu_rdata_hold", cpu_rdata, 16'h1234);
    // external write 0x0020 <- 0xBEEF
    ext_req = 1; ext_rw = 1; ext_addr = 16'h0020; ext_wdata = 16'hBEEF;
    #1;
    chk("ext_wr_gnt", ext_gnt, 1);
    chk("ext_wr_mem_rw", mem_rw, 1);
    chk("ext_wr_mem_addr", mem_addr, 16'h0020);
    chk("ext_wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    ext_req = 0;
    #1;
    chk("ext_wr_done", ext_done, 1);
    chk("ext_wr_gnt_off", ext_gnt, 0);
    tick();
    chk("ext_wr_done_off", ext_done, 0);
    chk("ext_wr_stored", mem[8'h20], 16'hBEEF);
    // starvation: CPU and ext both rise together, CPU holds four cycles
    cpu_en = 1; cpu_rw = 0; cpu_addr = 16'h0010;
    ext_req = 1; ext_rw = 0; ext_addr = 16'h0030;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("starve_c%0d_cnt", i), dut.starve_q, i - 1);
      chk($sformatf("starve_c%0d_gnt", i), ext_gnt, 0);
      chk($sformatf("starve_c%0d_stall", i), cpu_stall, 0);
      chk($sformatf("starve_c%0d_addr", i), mem_addr, 16'h0010);
      tick();
    end
    #1;
    chk("starve_c5_cnt", dut.starve_q, 4);
    chk("starve_c5_gnt", ext_gnt, 1);
    chk("starve_c5_stall", cpu_stall, 1);
    chk("starve_c5_addr", mem_addr, 16'h0030);
    sb.push_back(16'h5555);
    tick();
    ext_req = 0;
    #1;
    chk("starve_c6_cnt", dut.starve_q, 0);
    chk("starve_c6_stall", cpu_stall, 0);
    chk("starve_c6_addr", mem_addr, 16'h0010);
    chk("starve_c6_en", mem_en, 1);
    chk("starve_c6_done", ext_done, 1);
    chk("starve_c6_rdata", ext_rdata, sb.pop_front());
    tick();
    cpu_en = 0;
    chk("starve_c7_cpu_rdata", cpu_rdata, 16'h1234);
    // reset the cycle after a grant discards the response
    ext_req = 1; ext_rw = 0; ext_addr = 16'h0001;
    #1;
    chk("rst_mid_gnt", ext_gnt, 1);
    tick();
    ext_req = 0;
    reset = 0;
    #1;
    chk("rst_mid_done", ext_done, 0);
    chk("rst_mid_ext_rdata", ext_rdata, 0);
    chk("rst_mid_cpu_rdata", cpu_rdata, 0);
    chk("rst_mid_mem_en", mem_en, 0);
    chk("rst_mid_state", dut.state_q, IDLE);
    tick();
    reset = 1;
    #1;
    chk("rst_rel_state", dut.state_q, IDLE);
    chk("rst_rel_done", ext_done, 0);
    tick();
    chk("rst_rel_done2", ext_done, 0);
    // back-to-back external reads
    ext_req = 1; ext_rw = 0;
    for (int i = 0; i < 3; i++) begin
      ext_addr = 16'(i + 1);
      #1;
      chk($sformatf("b2b_gnt%0d", i), ext_gnt, 1);
      chk($sformatf("b2b_addr%0d", i), mem_addr, i + 1);
      if (i > 0) begin
        chk($sformatf("b2b_done%0d", i - 1), ext_done, 1);
        chk($sformatf("b2b_rdata%0d", i - 1), ext_rdata, sb.pop_front());
      end
      sb.push_back(16'(10 + i));
      tick();
    end
    ext_req = 0;
    #1;
    chk("b2b_done2", ext_done, 1);
    chk("b2b_rdata2", ext_rdata, sb.pop_front());
    chk("b2b_gnt_off", ext_gnt, 0);
    tick();
    chk("b2b_done_off", ext_done, 0);
    chk("b2b_rdata_hold", ext_rdata, 16'h000C);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
